// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice reused LSB first, start/done handshake.
// Optional signed-overflow output V enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             Busy,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             V,
`endif
  output logic             Done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             fa_sum;
  logic             fa_cout;
  logic             last;
  logic [WIDTH-1:0] s_next;

  // The single full-adder slice
  assign fa_sum  = a_sh[0] ^ b_sh[0] ^ carry;
  assign fa_cout = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  assign last    = (cnt == CW'(WIDTH - 1));
  assign s_next  = {fa_sum, s_sh[WIDTH-1:1]};

  assign Busy = (state == RUN);
  assign Done = (state == DONE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      C_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      V     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (Start) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= C_in;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= s_next;
          carry <= fa_cout;
          cnt   <= cnt + CW'(1);
          if (last) begin
            S     <= s_next;
            C_out <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
            // carry into MSB is the held carry; carry out is this slice's
            V     <= carry ^ fa_cout;
`endif
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
